input_scan_sequencer: RTL and testbench
=======================================

// Module: input_scan_sequencer
// PURPOSE
//  Raster-scan controller for the input ROM reader (fixed LATENCY-cycle read, no flow control).
//  - On a start pulse, walks (col,row) over the whole image in row-major order.
//  - Re-aligns returned pixels with their coordinates and frame markers.
//  - Delivers pixels on a valid/ready stream to the thresholding pipeline.
//  - Never drops a pixel under backpressure: issue is credit-limited against a small output FIFO.
// PARAMETERS
//  WIDTH_BITS   8  log2(image width); col counter width
//  HEIGHT_BITS  8  log2(image height); row counter width
//  LATENCY      2  cycles from address presented to matching reader data; must be >=1
//  FIFO_DEPTH   4  output FIFO entries; must be >= LATENCY+2 for 1 px/clk
// PORTS
//  clock     in   1            single clock, rising edge
//  reset_n   in   1            asynchronous, active-low reset
//  iStart    in   1            start one frame scan; sampled only in IDLE
//  oBusy     out  1            high from the edge sampling iStart until oDone
//  oDone     out  1            1-cycle pulse after the last pixel is accepted downstream
//  oCol      out  WIDTH_BITS   column address to the reader
//  oRow      out  HEIGHT_BITS  row address to the reader
//  iData     in   8            pixel from the reader, LATENCY cycles after address
//  oValid    out  1            output pixel valid (FIFO not empty)
//  iReady    in   1            downstream accepts; transfer = oValid & iReady
//  oPixel    out  8            pixel value
//  oPixCol   out  WIDTH_BITS   column of oPixel
//  oPixRow   out  HEIGHT_BITS  row of oPixel
//  oSof      out  1            oPixel is (0,0)
//  oEol      out  1            oPixel is the last column of its row
//  oEof      out  1            oPixel is the last pixel of the frame
// BEHAVIOUR
//  - Reset: state IDLE.
//    - oBusy, oDone, oValid = 0; oCol, oRow = 0.
//    - FIFO, tag pipe and counters are cleared.
//    - Asserting reset mid-scan aborts the frame; no pixel survives it.
//  - FSM IDLE -> SCAN -> DRAIN -> IDLE. No other states.
//    - IDLE: iStart=1 -> SCAN with col=row=0. iStart is ignored in every other state.
//    - SCAN: issue = (fifo_count + inflight < FIFO_DEPTH).
//    - On issue: push a tag {col,row,sof,eol,eof} into a LATENCY-stage pipe and advance col.
//      - col wraps to 0 and row increments at col = 2^WIDTH_BITS-1.
//      - Issuing the last pixel (both counters at max) -> DRAIN; counters return to 0.
//    - DRAIN: no issue. When the tag pipe and FIFO are empty -> IDLE, with oDone=1 for that one cycle.
//  - oCol/oRow are the live counters. They hold their value when not issuing.
//    - Reader data with no valid tag is discarded.
//  - inflight = number of valid tag-pipe stages. The pipe advances every cycle; no stall.
//  - When the pipe output is valid, {iData, tag} is written to the FIFO on that edge.
//    - The credit check guarantees the FIFO is never written when full.
//  - Simultaneous FIFO write and read is legal at any occupancy, including empty to 1 and full.
//  - Latency: iStart sampled at edge E0 -> oValid first high after edge E(LATENCY+1).
//  - Throughput: 1 px/clk with iReady held high.
//  - Backpressure: iReady=0 stalls issue once credits are exhausted.
//    - oPixel and the tag outputs hold stable while oValid & !iReady.
//  - Arithmetic: pixel index is unsigned, WIDTH_BITS+HEIGHT_BITS bits.
//    - Flags are computed at issue time, not at output.
// STRUCTURE
//  - Shared header scan_defs.vh:
//    - FSM state encodings S_IDLE, S_SCAN, S_DRAIN.
//    - Tag field widths: TAG_W = WIDTH_BITS+HEIGHT_BITS+3.
//  - One sub-module: pixel_fifo.
//    - Synchronous FIFO, parameterised width and depth, exposing count, full and empty.
//    - Async active-low reset.
//  - Counters, FSM and tag pipe are inline.
// TESTING (WIDTH_BITS=2, HEIGHT_BITS=2, LATENCY=2, FIFO_DEPTH=4; ROM model data = 8'hA0 + index)
//  1. Reset, iStart 1 cycle, iReady=1 -> 16 pixels A0..AF on consecutive cycles.
//     - First oValid 3 edges after start; oSof on A0; oEol on A3/A7/AB/AF; oEof on AF.
//     - oDone pulses once; oBusy then falls.
//  2. iReady=0 for 10 cycles after start -> oValid holds A0.
//     - At most 4 pixels buffered; oCol stops advancing.
//     - On release, A0..AF arrive with no gap, loss or duplicate.
//  3. Random iReady (50%) over 3 back-to-back frames -> each frame is exactly A0..AF in order.
//     - Coordinates match the data; exactly one oDone per frame.
//  4. iStart pulsed during SCAN and DRAIN -> ignored; exactly 16 pixels and one oDone.
//  5. reset_n low mid-frame (after 6 pixels) -> all outputs 0 immediately.
//     - A following iStart produces a clean frame from A0.
//  6. iReady=0 for the whole DRAIN -> oDone stays 0 until AF is accepted.
//     - oDone pulses on the cycle after AF's transfer edge.

Source files
------------

// File: rtl/input_scan_sequencer_pkg.sv
// Shared types for the input raster-scan sequencer: FSM encoding, frame flags, tag sizing.
package input_scan_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2
   } scan_state_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } scan_flags_t;

   // Tag carries {col, row, sof, eol, eof}.
   function automatic int tag_width(input int width_bits, input int height_bits);
      return width_bits + height_bits + 3;
   endfunction

endpackage

// File: rtl/input_scan_sequencer_pixel_fifo.sv
// Synchronous FIFO with count/full/empty; head data reads as zero while empty.
// Write and read in the same cycle are accepted at any occupancy, including full.
module pixel_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= bump(wr_ptr);
         if (do_rd) rd_ptr <= bump(rd_ptr);
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/input_scan_sequencer.sv
// Raster-scan address generator for a fixed-latency ROM reader; pixels re-tagged and streamed out.
// First pixel valid LATENCY+1 edges after start; issue is credit-limited so no pixel is lost under backpressure.
module input_scan_sequencer
   import input_scan_sequencer_pkg::*;
#(
   parameter int WIDTH_BITS  = 8,
   parameter int HEIGHT_BITS = 8,
   parameter int LATENCY     = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   iStart,
   output logic                   oBusy,
   output logic                   oDone,
   output logic [WIDTH_BITS-1:0]  oCol,
   output logic [HEIGHT_BITS-1:0] oRow,
   input  logic [7:0]             iData,
   output logic                   oValid,
   input  logic                   iReady,
   output logic [7:0]             oPixel,
   output logic [WIDTH_BITS-1:0]  oPixCol,
   output logic [HEIGHT_BITS-1:0] oPixRow,
   output logic                   oSof,
   output logic                   oEol,
   output logic                   oEof
);

   localparam int TAG_W = tag_width(WIDTH_BITS, HEIGHT_BITS);
   localparam int ENT_W = 8 + TAG_W;
   localparam int FCW   = $clog2(FIFO_DEPTH + 1);
   localparam int CW    = $clog2(FIFO_DEPTH + LATENCY + 1);

   typedef struct packed {
      logic [WIDTH_BITS-1:0]  col;
      logic [HEIGHT_BITS-1:0] row;
      scan_flags_t            flags;
   } tag_t;

   typedef struct packed {
      logic [7:0] pixel;
      tag_t       tag;
   } entry_t;

   scan_state_t            state;
   scan_state_t            state_nx;
   logic [WIDTH_BITS-1:0]  col;
   logic [HEIGHT_BITS-1:0] row;
   tag_t                   tag_q [LATENCY];
   logic [LATENCY-1:0]     vld_q;
   tag_t                   tag_new;
   logic [CW-1:0]          inflight;
   logic [CW-1:0]          used;
   logic [FCW-1:0]         fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   issue;
   logic                   last_px;
   logic                   done;
   entry_t                 wr_ent;
   entry_t                 rd_ent;

   assign last_px = (&col) && (&row);

   always_comb begin
      tag_new           = '0;
      tag_new.col       = col;
      tag_new.row       = row;
      tag_new.flags.sof = (col == '0) && (row == '0);
      tag_new.flags.eol = &col;
      tag_new.flags.eof = last_px;
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
   end

   // Every in-flight read already owns a FIFO slot, so a write can never hit a full FIFO.
   assign used  = CW'(fifo_count) + inflight;
   assign issue = (state == S_SCAN) && !fifo_full && (used < CW'(FIFO_DEPTH));

   always_comb begin
      state_nx = state;
      done     = 1'b0;
      case (state)
         S_IDLE:  if (iStart) state_nx = S_SCAN;
         S_SCAN:  if (issue && last_px) state_nx = S_DRAIN;
         S_DRAIN: begin
            if ((vld_q == '0) && fifo_empty) begin
               state_nx = S_IDLE;
               done     = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nx;
         if (issue) begin
            col <= col + WIDTH_BITS'(1);
            if (&col) row <= row + HEIGHT_BITS'(1);
         end
      end
   end

   // Tag pipe mirrors the reader latency; it never stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      end else begin
         vld_q[0] <= issue;
         tag_q[0] <= tag_new;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_comb begin
      wr_ent       = '0;
      wr_ent.pixel = iData;
      wr_ent.tag   = tag_q[LATENCY-1];
   end

   pixel_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (vld_q[LATENCY-1]),
      .wr_data (wr_ent),
      .rd_en   (iReady),
      .rd_data (rd_ent),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign oBusy   = (state != S_IDLE);
   assign oDone   = done;
   assign oCol    = col;
   assign oRow    = row;
   assign oValid  = !fifo_empty;
   assign oPixel  = rd_ent.pixel;
   assign oPixCol = rd_ent.tag.col;
   assign oPixRow = rd_ent.tag.row;
   assign oSof    = rd_ent.tag.flags.sof;
   assign oEol    = rd_ent.tag.flags.eol;
   assign oEof    = rd_ent.tag.flags.eof;

endmodule

// File: tb/tb_input_scan_sequencer.sv
// Self-checking bench for input_scan_sequencer on a 4x4 image with a 2-cycle ROM model (data = A0 + index).
module tb_input_scan_sequencer;

   localparam int WB = 2;
   localparam int HB = 2;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic          iStart  = 1'b0;
   logic          iReady  = 1'b0;
   logic [7:0]    iData   = 8'h00;
   logic          oBusy, oDone, oValid, oSof, oEol, oEof;
   logic [WB-1:0] oCol, oPixCol;
   logic [HB-1:0] oRow, oPixRow;
   logic [7:0]    oPixel;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   input_scan_sequencer #(
      .WIDTH_BITS  (WB),
      .HEIGHT_BITS (HB),
      .LATENCY     (2),
      .FIFO_DEPTH  (4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .iStart  (iStart),
      .oBusy   (oBusy),
      .oDone   (oDone),
      .oCol    (oCol),
      .oRow    (oRow),
      .iData   (iData),
      .oValid  (oValid),
      .iReady  (iReady),
      .oPixel  (oPixel),
      .oPixCol (oPixCol),
      .oPixRow (oPixRow),
      .oSof    (oSof),
      .oEol    (oEol),
      .oEof    (oEof)
   );

   // ROM model: address seen in one cycle returns its data two cycles later.
   logic [3:0] a1 = 4'h0;
   logic [3:0] a2 = 4'h0;
   always @(negedge clock) begin
      iData = 8'hA0 + {4'h0, a2};
      a2    = a1;
      a1    = {oRow, oCol};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [14:0] exp_word(input int idx);
      logic [3:0] i;
      i = idx[3:0];
      return {8'hA0 + {4'h0, i}, i[1:0], i[3:2], (i == 4'd0), (i[1:0] == 2'd3), (i == 4'd15)};
   endfunction

   // Scoreboard: every valid head must be the next expected pixel; oDone exactly one cycle after AF leaves.
   logic mon_en   = 1'b0;
   int   mon_idx  = 0;
   logic prev_eof = 1'b0;
   int   done_cnt = 0;
   always @(negedge clock) begin
      if (mon_en) begin
         check("done_timing", 32'(oDone), 32'(prev_eof));
         if (oDone) begin
            check("frame_len", 32'(mon_idx), 32'd16);
            mon_idx = 0;
            done_cnt++;
         end
         prev_eof = 1'b0;
         if (oValid) begin
            if (mon_idx > 15) check("extra_pixel", 32'(oValid), 32'd0);
            else check("pixel_word", 32'({oPixel, oPixCol, oPixRow, oSof, oEol, oEof}),
                       32'(exp_word(mon_idx)));
            if (iReady) begin
               prev_eof = (mon_idx == 15);
               mon_idx++;
            end
         end
      end
   end

   typedef struct packed {
      logic       start;
      logic       ready;
      logic       busy;
      logic       done;
      logic       valid;
      logic [7:0] pixel;
      logic [3:0] addr;
   } vec_t;

   vec_t vt [22];

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      int   base;
      int   gaps;
      int   n;

      // Frame 1 with iReady held high: start at vector 0, pixel k visible at vector k+4.
      for (int v = 0; v < 22; v++) begin
         vt[v].start = (v == 0);
         vt[v].ready = 1'b1;
         vt[v].busy  = (v >= 1) && (v <= 20);
         vt[v].done  = (v == 20);
         vt[v].valid = (v >= 4) && (v <= 19);
         vt[v].pixel = 8'hA0 + 8'(v - 4);
         vt[v].addr  = ((v >= 1) && (v <= 16)) ? 4'(v - 1) : 4'h0;
      end

      repeat (3) @(posedge clock);
      #1;
      check("reset_outputs", 32'({oBusy, oDone, oValid, oCol, oRow}), 32'd0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(posedge clock);
      #1;

      for (int v = 0; v < 22; v++) begin
         iStart = vt[v].start;
         iReady = vt[v].ready;
         @(negedge clock);
         check("t1_busy",  32'(oBusy),  32'(vt[v].busy));
         check("t1_done",  32'(oDone),  32'(vt[v].done));
         check("t1_valid", 32'(oValid), 32'(vt[v].valid));
         check("t1_addr",  32'({oRow, oCol}), 32'(vt[v].addr));
         if (vt[v].valid) check("t1_pixel", 32'(oPixel), 32'(vt[v].pixel));
         @(posedge clock);
         #1;
      end

      // Backpressure: 10 stalled cycles, exactly 4 reads issued, A0 held.
      iStart = 1'b1;
      iReady = 1'b0;
      @(posedge clock);
      #1;
      iStart = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (c == 5 || c == 10) check("t2_addr_stall", 32'({oRow, oCol}), 32'd4);
         if (c == 10) begin
            check("t2_valid_hold", 32'(oValid), 32'd1);
            check("t2_pixel_hold", 32'(oPixel), 32'hA0);
         end
         @(posedge clock);
         #1;
      end
      iReady = 1'b1;
      gaps = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clock);
         if (!oValid) gaps++;
         @(posedge clock);
         #1;
      end
      check("t2_no_gap", 32'(gaps), 32'd0);
      @(negedge clock);
      check("t2_done", 32'(oDone), 32'd1);
      @(posedge clock);
      #1;

      // Three back-to-back frames under random iReady.
      base = done_cnt;
      for (int f = 0; f < 3; f++) begin
         iStart = 1'b1;
         iReady = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
         iStart = 1'b0;
         got = 1'b0;
         for (int c = 0; c < 400 && !got; c++) begin
            iReady = 1'($urandom_range(0, 1));
            @(negedge clock);
            got = oDone;
            @(posedge clock);
            #1;
         end
         check("t3_frame_done", 32'(got), 32'd1);
      end
      check("t3_done_count", 32'(done_cnt - base), 32'd3);

      // iStart held through SCAN and DRAIN must not restart or extend the frame.
      base   = done_cnt;
      iReady = 1'b1;
      iStart = 1'b1;
      got    = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clock);
         got = oDone;
         @(posedge clock);
         #1;
      end
      iStart = 1'b0;
      check("t4_done_seen", 32'(got), 32'd1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("t4_idle_after", 32'(oBusy), 32'd0);
      check("t4_one_done", 32'(done_cnt - base), 32'd1);
      @(posedge clock);
      #1;

      // Reset after 6 pixels aborts the frame; next start gives a clean frame.
      iReady = 1'b1;
      iStart = 1'b1;
      @(posedge clock);
      #1;
      iStart = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clock);
         #1;
         got = (mon_idx >= 6);
      end
      check("t5_six_seen", 32'(got), 32'd1);
      @(posedge clock);
      #1;
      mon_en  = 1'b0;
      reset_n = 1'b0;
      #1;
      check("t5_reset_outputs",
            32'({oBusy, oDone, oValid, oCol, oRow, oPixel, oPixCol, oPixRow, oSof, oEol, oEof}), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n  = 1'b1;
      mon_idx  = 0;
      prev_eof = 1'b0;
      mon_en   = 1'b1;
      base     = done_cnt;
      iStart   = 1'b1;
      @(posedge clock);
      #1;
      iStart = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clock);
         got = oDone;
         @(posedge clock);
         #1;
      end
      check("t5_clean_frame", 32'(done_cnt - base), 32'd1);

      // Stall the whole DRAIN: oDone must wait for AF's transfer.
      iReady = 1'b1;
      iStart = 1'b1;
      @(posedge clock);
      #1;
      iStart = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge clock);
         got = oBusy && ({oRow, oCol} == 4'd15);
         @(posedge clock);
         #1;
      end
      check("t6_last_issue_seen", 32'(got), 32'd1);
      iReady = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         check("t6_hold_done", 32'(oDone), 32'd0);
         check("t6_hold_valid", 32'(oValid), 32'd1);
         @(posedge clock);
         #1;
      end
      iReady = 1'b1;
      got = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clock);
         got = oDone;
         if (!got) n++;
         @(posedge clock);
         #1;
      end
      check("t6_done", 32'(got), 32'd1);
      check("t6_release_to_done", 32'(n), 32'd3);

      repeat (2) @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
